reg_file_phased: RTL and testbench



---
 rtl/reg_file_phased_pkg.sv | 25 ++
 rtl/reg_file_phased_phase_counter.sv | 30 +++
 rtl/reg_file_phased.sv | 75 +++++++
 tb/tb_reg_file_phased.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/reg_file_phased_pkg.sv
// Shared phase table and widths for the phased multicycle datapath stages.
package reg_file_phased_pkg;

  localparam int unsigned NUM_PHASES   = 10;
  localparam int unsigned READ_PHASE   = 2;
  localparam int unsigned WB_MUX_PHASE = 5;
  // Commit only after the write-back mux has settled, and away from the read phase.
  localparam int unsigned WRITE_PHASE  = 6;
  localparam int unsigned PHASE_W      = 4;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 2 ** ADDR_W;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef logic [PHASE_W-1:0] phase_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/reg_file_phased_phase_counter.sv
// Modulo-N phase counter with synchronous reset and a combinational next-phase view.
module phase_counter
  import reg_file_phased_pkg::*;
#(
  parameter int unsigned N = NUM_PHASES,
  parameter int unsigned W = PHASE_W
) (
  input  logic         clock,
  input  logic         reset,
  output logic [W-1:0] o_phase,
  output logic [W-1:0] o_ph_next_c
);

  logic [W-1:0] r_phase;
  logic [W-1:0] w_ph_next;

  always_comb begin
    w_ph_next = r_phase + W'(1);
    if (r_phase == W'(N - 1)) w_ph_next = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) r_phase <= '0;
    else       r_phase <= w_ph_next;
  end

  assign o_phase     = r_phase;
  assign o_ph_next_c = w_ph_next;

endmodule

// File: rtl/reg_file_phased.sv
// 32x32 register file, two read ports and one write port, keyed to the datapath phase cycle.
module reg_file_phased
  import reg_file_phased_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              regWrite,
  input  logic [ADDR_W-1:0] readReg1,
  input  logic [ADDR_W-1:0] readReg2,
  input  logic [ADDR_W-1:0] writeReg,
  input  logic [DATA_W-1:0] writeData,
  output logic [DATA_W-1:0] readData1,
  output logic [DATA_W-1:0] readData2,
  output logic [PHASE_W-1:0] phase,
  output logic              writeDone
);

  phase_t            w_phase;
  phase_t            w_ph_next;
  wb_req_t           w_wb_req;
  logic              w_read_fire;
  logic              w_write_fire;
  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [DATA_W-1:0] r_read_data1;
  logic [DATA_W-1:0] r_read_data2;
  logic              r_write_done;

  phase_counter #(
    .N (NUM_PHASES),
    .W (PHASE_W)
  ) u_phase_counter (
    .clock       (clock),
    .reset       (reset),
    .o_phase     (w_phase),
    .o_ph_next_c (w_ph_next)
  );

  assign w_wb_req = '{we: regWrite, addr: writeReg, data: writeData};

  // Actions are keyed to the phase being entered on this edge.
  assign w_read_fire  = (w_ph_next == PHASE_W'(READ_PHASE));
  assign w_write_fire = (w_ph_next == PHASE_W'(WRITE_PHASE)) && w_wb_req.we
                        && (w_wb_req.addr != REG_ZERO);

  assign w_rd1 = (readReg1 == REG_ZERO) ? '0 : r_regs[readReg1];
  assign w_rd2 = (readReg2 == REG_ZERO) ? '0 : r_regs[readReg2];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_read_data1 <= '0;
      r_read_data2 <= '0;
      r_write_done <= 1'b0;
    end else begin
      r_write_done <= 1'b0;
      if (w_read_fire) begin
        r_read_data1 <= w_rd1;
        r_read_data2 <= w_rd2;
      end
      if (w_write_fire) begin
        r_regs[w_wb_req.addr] <= w_wb_req.data;
        r_write_done          <= 1'b1;
      end
    end
  end

  assign readData1 = r_read_data1;
  assign readData2 = r_read_data2;
  assign phase     = w_phase;
  assign writeDone = r_write_done;

endmodule

// File: tb/tb_reg_file_phased.sv
// Self-checking bench for reg_file_phased: directed phase-cycle table, corner sequences, random run.
module tb_reg_file_phased;

  logic        clock = 1'b0;
  logic        reset;
  logic        regWrite;
  logic [4:0]  readReg1, readReg2, writeReg;
  logic [31:0] writeData;
  logic [31:0] readData1, readData2;
  logic [3:0]  phase;
  logic        writeDone;

  always #5 clock = ~clock;

  reg_file_phased dut (
    .clock     (clock),
    .reset     (reset),
    .regWrite  (regWrite),
    .readReg1  (readReg1),
    .readReg2  (readReg2),
    .writeReg  (writeReg),
    .writeData (writeData),
    .readData1 (readData1),
    .readData2 (readData2),
    .phase     (phase),
    .writeDone (writeDone)
  );

  int total = 0;
  int bad   = 0;
  int pulses = 0;

  // Reference model: phase as an integer, register file as a plain array.
  int          m_ph;
  logic [31:0] m_regs [32];
  logic [31:0] m_rd1, m_rd2;
  logic        m_wd;

  typedef struct {
    logic        we;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] e1;
    logic [31:0] e2;
    int          epulse;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic rst, input logic we, input logic [4:0] wr,
                            input logic [31:0] d, input logic [4:0] r1, input logic [4:0] r2);
    int nxt;
    if (rst) begin
      m_ph = 0; m_rd1 = 0; m_rd2 = 0; m_wd = 0;
      for (int i = 0; i < 32; i++) m_regs[i] = 0;
    end else begin
      nxt  = (m_ph + 1) % 10;
      m_wd = 1'b0;
      if (nxt == 2) begin
        m_rd1 = (r1 == 0) ? 32'd0 : m_regs[r1];
        m_rd2 = (r2 == 0) ? 32'd0 : m_regs[r2];
      end
      if (nxt == 6 && we && wr != 0) begin
        m_regs[wr] = d;
        m_wd       = 1'b1;
      end
      m_ph = nxt;
    end
  endtask

  // One clock edge: model follows the inputs present at the edge, outputs checked 1 time unit later.
  task automatic tick();
    logic rst, we;
    logic [4:0] wr, r1, r2;
    logic [31:0] d;
    rst = reset; we = regWrite; wr = writeReg; d = writeData; r1 = readReg1; r2 = readReg2;
    @(posedge clock);
    model_edge(rst, we, wr, d, r1, r2);
    #1;
    if (writeDone === 1'b1) pulses++;
    chk("phase", 32'(phase), 32'(m_ph));
    chk("readData1", readData1, m_rd1);
    chk("readData2", readData2, m_rd2);
    chk("writeDone", 32'(writeDone), 32'(m_wd));
  endtask

  task automatic run_cycle(input vec_t v, input int idx);
    chk($sformatf("vec%0d_start_phase", idx), 32'(phase), 32'd0);
    regWrite = v.we; writeReg = v.wr; writeData = v.wd; readReg1 = v.r1; readReg2 = v.r2;
    pulses = 0;
    repeat (10) tick();
    chk($sformatf("vec%0d_rd1", idx), readData1, v.e1);
    chk($sformatf("vec%0d_rd2", idx), readData2, v.e2);
    chk($sformatf("vec%0d_pulses", idx), 32'(pulses), 32'(v.epulse));
  endtask

  initial begin
    vecs[0] = '{1'b1, 5'd8,  32'hDEADBEEF, 5'd0,  5'd0,  32'd0,        32'd0,        1};
    vecs[1] = '{1'b0, 5'd8,  32'h0,        5'd8,  5'd0,  32'hDEADBEEF, 32'd0,        0};
    vecs[2] = '{1'b1, 5'd0,  32'h12345678, 5'd0,  5'd8,  32'd0,        32'hDEADBEEF, 0};
    vecs[3] = '{1'b1, 5'd3,  32'd7,        5'd0,  5'd0,  32'd0,        32'd0,        1};
    vecs[4] = '{1'b1, 5'd4,  32'd9,        5'd3,  5'd0,  32'd7,        32'd0,        1};
    vecs[5] = '{1'b0, 5'd4,  32'd0,        5'd3,  5'd4,  32'd7,        32'd9,        0};
    vecs[6] = '{1'b0, 5'd0,  32'd0,        5'd31, 5'd3,  32'd0,        32'd7,        0};
    vecs[7] = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd4,  5'd31, 32'd9,        32'd0,        1};
    vecs[8] = '{1'b0, 5'd0,  32'd0,        5'd31, 5'd0,  32'hFFFFFFFF, 32'd0,        0};

    reset = 1'b1; regWrite = 1'b0; writeReg = 0; writeData = 0; readReg1 = 0; readReg2 = 0;
    m_ph = 0; m_rd1 = 0; m_rd2 = 0; m_wd = 0;
    for (int i = 0; i < 32; i++) m_regs[i] = 0;

    // Reset held three cycles, then the bare phase sequence.
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_rd1", readData1, 32'd0);
    chk("rst_rd2", readData2, 32'd0);
    chk("rst_wd", 32'(writeDone), 32'd0);
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("phase_seq", 32'(phase), 32'(k % 10));
    end

    // Table: each entry is one full phase cycle with constant inputs.
    for (int i = 0; i < 5; i++) run_cycle(vecs[i], i);

    // Dual-read operands hold when indices change after the read phase.
    readReg1 = 5'd3; readReg2 = 5'd4; regWrite = 1'b0;
    repeat (4) tick();
    readReg1 = 5'd8; readReg2 = 5'd0;
    repeat (6) tick();
    chk("hold_rd1", readData1, 32'd7);
    chk("hold_rd2", readData2, 32'd9);

    for (int i = 5; i < 9; i++) run_cycle(vecs[i], i);

    // Write request dropped before the write phase leaves R5 untouched.
    regWrite = 1'b1; writeReg = 5'd5; writeData = 32'hAAAA0000; pulses = 0;
    repeat (5) tick();
    regWrite = 1'b0;
    repeat (5) tick();
    chk("early_we_pulses", 32'(pulses), 32'd0);
    run_cycle('{1'b0, 5'd5, 32'h0, 5'd5, 5'd0, 32'd0, 32'd0, 0}, 9);

    // Reset at phase 5 discards the pending write.
    regWrite = 1'b1; writeReg = 5'd9; writeData = 32'h55; pulses = 0;
    repeat (5) tick();
    chk("pre_rst_phase", 32'(phase), 32'd5);
    reset = 1'b1;
    tick();
    chk("mid_rst_phase", 32'(phase), 32'd0);
    chk("mid_rst_wd", 32'(writeDone), 32'd0);
    reset = 1'b0; regWrite = 1'b0;
    tick();
    chk("mid_rst_pulses", 32'(pulses), 32'd0);
    repeat (9) tick();
    run_cycle('{1'b0, 5'd0, 32'h0, 5'd9, 5'd9, 32'd0, 32'd0, 0}, 10);

    // Random traffic against the model, with occasional resets.
    for (int n = 0; n < 600; n++) begin
      reset     = ($urandom_range(0, 79) == 0);
      regWrite  = 1'($urandom_range(0, 1));
      writeReg  = 5'($urandom);
      writeData = $urandom;
      readReg1  = 5'($urandom);
      readReg2  = 5'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
